// File: rtl/key_scan_pkg.sv
// Shared debounce-state encodings and helper functions for the key scan arbiter.
package key_scan_pkg;

  typedef logic [1:0] db_state_t;

  // Bit 0 of each encoding is the debounced level (S2, S3 read as pressed).
  localparam db_state_t S0 = 2'b00;
  localparam db_state_t S1 = 2'b10;
  localparam db_state_t S2 = 2'b11;
  localparam db_state_t S3 = 2'b01;

  localparam int unsigned MaxKeys = 16;

  function automatic db_state_t next_db_state(input db_state_t state, input logic d);
    db_state_t nxt;
    case (state)
      S0:      nxt = d ? S1 : S0;
      S1:      nxt = d ? S2 : S0;
      S2:      nxt = d ? S2 : S3;
      default: nxt = d ? S2 : S0;
    endcase
    return nxt;
  endfunction

  function automatic int unsigned lowest_set_idx(input logic [MaxKeys-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = MaxKeys - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_scan_arbiter_if.sv
// Key input / selected-note bundle; master is the arbiter, slave is the consumer.
interface key_scan_arbiter_if #(
  parameter int unsigned N_KEYS = 8,
  parameter int unsigned IDX_W  = $clog2(N_KEYS)
);
  logic [N_KEYS-1:0] keys_in;
  logic [N_KEYS-1:0] db_keys;
  logic [IDX_W-1:0]  note_idx;
  logic              note_valid;
  logic              note_event;

  modport master (
    input  keys_in,
    output db_keys,
    output note_idx,
    output note_valid,
    output note_event
  );

  modport slave (
    output keys_in,
    input  db_keys,
    input  note_idx,
    input  note_valid,
    input  note_event
  );
endinterface

// File: rtl/scan_tick_gen.sv
// Scan prescaler and key pointer: one tick every TICK_DIV clks, pointer steps per tick.
module scan_tick_gen #(
  parameter int unsigned N_KEYS   = 8,
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned PTR_W    = $clog2(N_KEYS)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             tick_o,
  output logic [PTR_W-1:0] ptr_o
);
  localparam int unsigned CntW = $clog2(TICK_DIV);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    tick_o = (cnt_q == CntW'(TICK_DIV - 1));
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
    ptr_d  = ptr_q;
    if (tick_o) begin
      ptr_d = (ptr_q == PTR_W'(N_KEYS - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ptr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/key_scan_arbiter.sv
// Time-shared key debouncer plus note arbiter. Define LAST_NOTE_PRIORITY_EN for
// last-pressed priority; otherwise the lowest-index pressed key wins.
module key_scan_arbiter
  import key_scan_pkg::*;
#(
  parameter int unsigned N_KEYS   = 8,
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned IDX_W    = $clog2(N_KEYS)
) (
  input logic                clk,
  input logic                rst,
  key_scan_arbiter_if.master bus
);

  logic                           tick;
  logic [IDX_W-1:0]               ptr;
  logic [N_KEYS-1:0]              sync1_q, sync2_q;
  db_state_t [N_KEYS-1:0]         state_q;
  logic [N_KEYS-1:0]              db_keys;
  logic [IDX_W-1:0]               lowest_idx;
  logic [IDX_W-1:0]               note_idx_q, note_idx_d;
  logic                           note_valid_q, note_valid_d;
  logic                           note_event_q, note_event_d;

  scan_tick_gen #(
    .N_KEYS  (N_KEYS),
    .TICK_DIV(TICK_DIV),
    .PTR_W   (IDX_W)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .tick_o(tick),
    .ptr_o (ptr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.keys_in;
      sync2_q <= sync1_q;
    end
  end

  // Single evaluator: only the pointed-to key's state is rewritten per tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
    end else if (tick) begin
      state_q[ptr] <= next_db_state(state_q[ptr], sync2_q[ptr]);
    end
  end

  always_comb begin
    for (int k = 0; k < N_KEYS; k++) begin
      db_keys[k] = state_q[k][0];
    end
  end

  assign lowest_idx = IDX_W'(lowest_set_idx(MaxKeys'(db_keys)));

`ifdef LAST_NOTE_PRIORITY_EN
  logic [N_KEYS-1:0] db_prev_q;
  logic [N_KEYS-1:0] rise;
  logic [IDX_W-1:0]  rise_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_prev_q <= '0;
    end else begin
      db_prev_q <= db_keys;
    end
  end

  assign rise     = db_keys & ~db_prev_q;
  assign rise_idx = IDX_W'(lowest_set_idx(MaxKeys'(rise)));
`endif

  always_comb begin
    note_valid_d = |db_keys;
    note_idx_d   = note_idx_q;
`ifdef LAST_NOTE_PRIORITY_EN
    if (|rise) begin
      note_idx_d = rise_idx;
    end else if (note_valid_d && !db_keys[note_idx_q]) begin
      note_idx_d = lowest_idx;
    end
`else
    if (note_valid_d) begin
      note_idx_d = lowest_idx;
    end
`endif
    note_event_d = (note_idx_d != note_idx_q) || (note_valid_d != note_valid_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_idx_q   <= '0;
      note_valid_q <= 1'b0;
      note_event_q <= 1'b0;
    end else begin
      note_idx_q   <= note_idx_d;
      note_valid_q <= note_valid_d;
      note_event_q <= note_event_d;
    end
  end

  assign bus.db_keys    = db_keys;
  assign bus.note_idx   = note_idx_q;
  assign bus.note_valid = note_valid_q;
  assign bus.note_event = note_event_q;

endmodule

// File: tb/tb_key_scan_arbiter.sv
// Directed bench for key_scan_arbiter with N_KEYS=8, TICK_DIV=4 (32-clk scan period).
module tb_key_scan_arbiter;
  localparam int unsigned NK = 8;
  localparam int unsigned TD = 4;
  localparam int unsigned IW = 3;
  localparam int unsigned ScanClks = NK * TD;

  logic clk = 1'b0;
  logic rst;

  key_scan_arbiter_if #(.N_KEYS(NK), .IDX_W(IW)) bus_if ();

  key_scan_arbiter #(
    .N_KEYS  (NK),
    .TICK_DIV(TD),
    .IDX_W   (IW)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NK-1:0] keys;
    logic [NK-1:0] db;
    logic [IW-1:0] idx;
    logic          valid;
    int            ev;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   ev;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void add_vec(input logic [NK-1:0] keys, input logic [NK-1:0] db,
                                  input logic [IW-1:0] idx, input logic valid, input int evn);
    tbl.push_back('{keys, db, idx, valid, evn});
  endfunction

  // One full scan window; counts note_event pulses seen after each edge.
  task automatic run_scan(output int evn);
    evn = 0;
    repeat (ScanClks) begin
      @(posedge clk);
      @(negedge clk);
      evn += int'(bus_if.note_event);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Independent tick/pointer model: posedges since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("tick", int'(u_dut.tick), int'((cyc % TD) == TD - 1));
      check("ptr", int'(u_dut.ptr), (cyc / TD) % NK);
    end
  end

  initial begin
    bus_if.keys_in = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst db_keys", int'(bus_if.db_keys), 0);
    check("rst note_idx", int'(bus_if.note_idx), 0);
    check("rst note_valid", int'(bus_if.note_valid), 0);
    check("rst note_event", int'(bus_if.note_event), 0);
    check("rst ptr", int'(u_dut.ptr), 0);
    rst = 1'b0;

    add_vec(8'h00, 8'h00, 3'd0, 1'b0, 0);
    add_vec(8'h20, 8'h00, 3'd0, 1'b0, 0);
    add_vec(8'h20, 8'h20, 3'd5, 1'b1, 1);
    add_vec(8'h20, 8'h20, 3'd5, 1'b1, 0);
    add_vec(8'h24, 8'h20, 3'd5, 1'b1, 0);
    add_vec(8'h20, 8'h20, 3'd5, 1'b1, 0);
    add_vec(8'h00, 8'h20, 3'd5, 1'b1, 0);
    add_vec(8'h00, 8'h00, 3'd5, 1'b0, 1);
    add_vec(8'h04, 8'h00, 3'd5, 1'b0, 0);
    add_vec(8'h00, 8'h00, 3'd5, 1'b0, 0);
    add_vec(8'h04, 8'h00, 3'd5, 1'b0, 0);
    add_vec(8'h04, 8'h04, 3'd2, 1'b1, 1);
    add_vec(8'h00, 8'h04, 3'd2, 1'b1, 0);
    add_vec(8'h04, 8'h04, 3'd2, 1'b1, 0);
    add_vec(8'h00, 8'h04, 3'd2, 1'b1, 0);
    add_vec(8'h00, 8'h00, 3'd2, 1'b0, 1);
    add_vec(8'h02, 8'h00, 3'd2, 1'b0, 0);
    add_vec(8'h02, 8'h02, 3'd1, 1'b1, 1);
    add_vec(8'h42, 8'h02, 3'd1, 1'b1, 0);
`ifdef LAST_NOTE_PRIORITY_EN
    add_vec(8'h42, 8'h42, 3'd6, 1'b1, 1);
    add_vec(8'h02, 8'h42, 3'd6, 1'b1, 0);
    add_vec(8'h02, 8'h02, 3'd1, 1'b1, 1);
`else
    add_vec(8'h42, 8'h42, 3'd1, 1'b1, 0);
    add_vec(8'h02, 8'h42, 3'd1, 1'b1, 0);
    add_vec(8'h02, 8'h02, 3'd1, 1'b1, 0);
`endif
    add_vec(8'h00, 8'h02, 3'd1, 1'b1, 0);
    add_vec(8'h00, 8'h00, 3'd1, 1'b0, 1);
    add_vec(8'h40, 8'h00, 3'd1, 1'b0, 0);
    add_vec(8'h40, 8'h40, 3'd6, 1'b1, 1);
    add_vec(8'h42, 8'h40, 3'd6, 1'b1, 0);
    add_vec(8'h42, 8'h42, 3'd1, 1'b1, 1);
    add_vec(8'h40, 8'h42, 3'd1, 1'b1, 0);
    add_vec(8'h40, 8'h40, 3'd6, 1'b1, 1);
    add_vec(8'h00, 8'h40, 3'd6, 1'b1, 0);
    add_vec(8'h00, 8'h00, 3'd6, 1'b0, 1);

    foreach (tbl[i]) begin
      bus_if.keys_in = tbl[i].keys;
      run_scan(ev);
      check($sformatf("row%0d db_keys", i), int'(bus_if.db_keys), int'(tbl[i].db));
      check($sformatf("row%0d note_idx", i), int'(bus_if.note_idx), int'(tbl[i].idx));
      check($sformatf("row%0d note_valid", i), int'(bus_if.note_valid), int'(tbl[i].valid));
      check($sformatf("row%0d events", i), ev, tbl[i].ev);
    end

    // Key 7 is the last slot of the scan: its state lands on the 32nd edge.
    bus_if.keys_in = 8'h80;
    run_scan(ev);
    check("k7 first sample db", int'(bus_if.db_keys), 0);
    check("k7 first sample events", ev, 0);
    repeat (ScanClks - 1) step();
    check("k7 before tick db", int'(bus_if.db_keys), 0);
    step();
    check("k7 tick db", int'(bus_if.db_keys), 8'h80);
    check("k7 valid lags db", int'(bus_if.note_valid), 0);
    check("k7 event lags db", int'(bus_if.note_event), 0);
    step();
    check("k7 note_valid", int'(bus_if.note_valid), 1);
    check("k7 note_idx", int'(bus_if.note_idx), 7);
    check("k7 event pulse", int'(bus_if.note_event), 1);
    step();
    check("k7 event one cycle", int'(bus_if.note_event), 0);

    // Fresh start, then reset in the middle of a scan with key 3 held in S2.
    bus_if.keys_in = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus_if.keys_in = 8'h08;
    run_scan(ev);
    run_scan(ev);
    check("k3 db before reset", int'(bus_if.db_keys), 8'h08);
    check("k3 idx before reset", int'(bus_if.note_idx), 3);
    check("k3 valid before reset", int'(bus_if.note_valid), 1);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst db_keys", int'(bus_if.db_keys), 0);
    check("midrst note_valid", int'(bus_if.note_valid), 0);
    check("midrst note_idx", int'(bus_if.note_idx), 0);
    check("midrst ptr", int'(u_dut.ptr), 0);
    @(negedge clk);
    rst = 1'b0;
    run_scan(ev);
    check("restart first scan db", int'(bus_if.db_keys), 0);
    run_scan(ev);
    check("restart second scan db", int'(bus_if.db_keys), 8'h08);
    check("restart note_idx", int'(bus_if.note_idx), 3);
    check("restart events", ev, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
